demux1to2_32bit_reg: RTL and testbench
======================================

# demux1to2_32bit_reg

Registered 1-to-2 demultiplexer for 32-bit words, the inverse of the 2:1 32-bit mux. A word presented on one input port is steered by `Sel` into one of two independent output registers, each with its own valid/ready handshake. The block sits between a single producer and two consumers in the datapath lab designs. Back-pressure is applied per output, so one stalled consumer never blocks words steered to the other.

## Interface
Parameters:
- `WIDTH`, default 32: data width of `In`, `A` and `B`.
- `CNT_W`, default 8: width of each delivered-word counter.

Ports:
- `Clk` input, 1 bit: single clock. All state changes on the rising edge.
- `Reset` input, 1 bit: reset is synchronous and active-high.
- `In_Valid` input, 1 bit: `In` and `Sel` carry a word.
- `In_Ready` output, 1 bit: the block accepts the word this cycle.
- `Sel` input, 1 bit: destination select. 0 selects A; 1 selects B. Sampled only with `In_Valid`.
- `In` input, `WIDTH` bits: input word.
- `A_Valid` output, 1 bit: the output A register holds a word.
- `A_Ready` input, 1 bit: consumer A accepts the word this cycle.
- `A` output, `WIDTH` bits: output A data.
- `B_Valid` output, 1 bit; `B_Ready` input, 1 bit; `B` output, `WIDTH` bits: same behaviour as the A side.
- `Count_A` output, `CNT_W` bits: number of words delivered on A.
- `Count_B` output, `CNT_W` bits: number of words delivered on B.

## Operation
- Input transfer occurs when `In_Valid && In_Ready`.
- Output transfer occurs when `X_Valid && X_Ready`, where X is A or B.
- `In_Ready` is combinational:
  - `Sel ? (!B_Valid || B_Ready) : (!A_Valid || A_Ready)`.
  - It depends only on the selected side. The unselected side's state is irrelevant.
- Each output side is a one-entry register with two states, EMPTY (`X_Valid`=0) and FULL (`X_Valid`=1).
  - EMPTY, with a load: go to FULL and capture `In` into `X`.
  - FULL, drained and not loaded: go to EMPTY. `X` keeps its last value.
  - FULL, drained and loaded in the same cycle: stay FULL and replace `X` with `In`. There is no bubble.
  - FULL, not drained: hold. `X` and `X_Valid` must not change, and any input word for this side is refused.
- Steering: a word is loaded into A if `Sel`=0 and into B if `Sel`=1. It is never loaded into both.
- The unselected side continues to drain independently in the same cycle.
- `X` data is stable whenever `X_Valid`=1 and `X_Ready`=0.
- Counters:
  - `Count_X` increments by 1 on each output transfer on X.
  - Each counter wraps modulo 2^`CNT_W` (255 → 0 at the default width).
  - A and B transfers in the same cycle increment both counters.
- `In_Valid`=0 has no effect on state, whatever the value of `Sel`.

## Timing
- Latency: a word accepted at edge N appears with `X_Valid`=1 after edge N. This is one cycle.
- Throughput: one word per cycle per side, sustained while the consumer holds `X_Ready`=1.
- Reset values:
  - `A_Valid`=0, `B_Valid`=0.
  - `A`=0, `B`=0.
  - `Count_A`=0, `Count_B`=0.
  - `In_Ready` then evaluates to 1 for either value of `Sel`.
- Reset has priority over every transfer in the same cycle.
- Reset mid-operation discards any pending A/B words and clears the counters. Words in flight are not delivered.
- `X_Ready` may toggle freely while `X_Valid`=0. It has no effect then.

## Configuration
- Macro: `DEMUX1TO2_COUNT_EN`.
- Defined: `Count_A` and `Count_B` operate as described above.
- Not defined:
  - The counter registers are not built.
  - `Count_A` and `Count_B` are tied to constant 0.
  - The port list is unchanged, and all other behaviour is identical.

## Test plan
- Reset, then `Sel`=0, `In`=32'hAAAAAAAA, `In_Valid`=1 for one cycle, with `A_Ready`=1 → next cycle `A_Valid`=1, `A`=AAAAAAAA, `B_Valid`=0, `Count_A`=1 one cycle later.
- `Sel`=1, `In`=32'h55555555 with `B_Ready`=0 → `B_Valid`=1, `B`=55555555. A second word 32'h87654321 with `Sel`=1 sees `In_Ready`=0 and `B` stays 55555555. Then raise `B_Ready` → the word is accepted that cycle and `B`=87654321 next cycle.
- Stall B (`B_Valid`=1, `B_Ready`=0), then send 32'h12345678 with `Sel`=0 → `In_Ready`=1, `A`=12345678, `B` unchanged.
- Streaming: 4 words on `Sel`=0 back-to-back, `A_Ready`=1 throughout → `In_Ready` stays 1, with no bubble. `Count_A`=4 two cycles after the last input (one cycle load, one cycle deliver).
- Wrap: deliver 256 words on B → `Count_B`=0 at the end (with `DEMUX1TO2_COUNT_EN` defined). Without the macro, `Count_B`=0 throughout.
- Assert `Reset` while `A_Valid`=1 and `B_Valid`=1 → next cycle both valids are 0, `A`=`B`=0, counters are 0, and `In_Ready`=1.

Source files
------------

// File: rtl/demux1to2_32bit_reg.sv
// rtl/demux1to2_32bit_reg.sv - registered 1:2 demux with per-side valid/ready and delivered-word counters
// Define DEMUX1TO2_COUNT_EN to build the Count_A/Count_B counters; otherwise they read constant 0.
module demux1to2_32bit_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Sel,
    input  logic [WIDTH-1:0] In,
    output logic             A_Valid,
    input  logic             A_Ready,
    output logic [WIDTH-1:0] A,
    output logic             B_Valid,
    input  logic             B_Ready,
    output logic [WIDTH-1:0] B,
    output logic [CNT_W-1:0] Count_A,
    output logic [CNT_W-1:0] Count_B
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      a_state_q, a_state_d;
    slot_state_e      b_state_q, b_state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             load_a, load_b;
    logic             drain_a, drain_b;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_state_q <= EMPTY;
            b_state_q <= EMPTY;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    // Each side may accept a new word in the same cycle it drains, so streaming has no bubble.
    always_comb begin
        a_state_d = a_state_q;
        b_state_d = b_state_q;
        a_d       = load_a ? In : a_q;
        b_d       = load_b ? In : b_q;
        case (a_state_q)
            EMPTY:   if (load_a) a_state_d = FULL;
            FULL:    if (drain_a && !load_a) a_state_d = EMPTY;
            default: a_state_d = EMPTY;
        endcase
        case (b_state_q)
            EMPTY:   if (load_b) b_state_d = FULL;
            FULL:    if (drain_b && !load_b) b_state_d = EMPTY;
            default: b_state_d = EMPTY;
        endcase
    end

    always_comb begin
        A_Valid  = (a_state_q == FULL);
        B_Valid  = (b_state_q == FULL);
        A        = a_q;
        B        = b_q;
        drain_a  = A_Valid && A_Ready;
        drain_b  = B_Valid && B_Ready;
        // Readiness looks only at the selected side, so a stalled consumer never blocks the other.
        In_Ready = Sel ? (!B_Valid || B_Ready) : (!A_Valid || A_Ready);
        load_a   = In_Valid && In_Ready && !Sel;
        load_b   = In_Valid && In_Ready && Sel;
    end

`ifdef DEMUX1TO2_COUNT_EN
    logic [CNT_W-1:0] count_a_q, count_a_d;
    logic [CNT_W-1:0] count_b_q, count_b_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_a_q <= '0;
            count_b_q <= '0;
        end else begin
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
        end
    end

    always_comb begin
        count_a_d = drain_a ? count_a_q + 1'b1 : count_a_q;
        count_b_d = drain_b ? count_b_q + 1'b1 : count_b_q;
        Count_A   = count_a_q;
        Count_B   = count_b_q;
    end
`else
    assign Count_A = '0;
    assign Count_B = '0;
`endif

endmodule

// File: tb/tb_demux1to2_32bit_reg.sv
// tb/tb_demux1to2_32bit_reg.sv - self-checking bench for demux1to2_32bit_reg
module tb_demux1to2_32bit_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic             Sel = 1'b0;
    logic [WIDTH-1:0] In = '0;
    logic             A_Valid;
    logic             A_Ready = 1'b0;
    logic [WIDTH-1:0] A;
    logic             B_Valid;
    logic             B_Ready = 1'b0;
    logic [WIDTH-1:0] B;
    logic [CNT_W-1:0] Count_A;
    logic [CNT_W-1:0] Count_B;

    int checks = 0;
    int errors = 0;

    demux1to2_32bit_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Sel(Sel), .In(In),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A(A),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B(B),
        .Count_A(Count_A), .Count_B(Count_B)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        s;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        ir;
        logic        av;
        logic [31:0] a;
        logic        bv;
        logic [31:0] b;
        int          ca;
        int          cb;
    } vec_t;

    vec_t vec[17];

    // Expected counter value: delivered-word count modulo 2^CNT_W, or 0 when counters are not built.
    function automatic logic [CNT_W-1:0] ec(input int n);
`ifdef DEMUX1TO2_COUNT_EN
        return CNT_W'(n % (1 << CNT_W));
`else
        return CNT_W'(n * 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic s, input logic [31:0] d,
                         input logic ar, input logic br);
        @(negedge Clk);
        Reset = rst; In_Valid = v; Sel = s; In = d; A_Ready = ar; B_Ready = br;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: each side is a queue of at most one pending word.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] last_a, last_b;
    int          m_ca, m_cb;

    task automatic model_reset();
        qa.delete(); qb.delete();
        last_a = '0; last_b = '0;
        m_ca = 0; m_cb = 0;
    endtask

    function automatic logic model_ready(input logic s, input logic ar, input logic br);
        return s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
    endfunction

    task automatic model_step(input logic rst, input logic v, input logic s, input logic [31:0] d,
                              input logic ar, input logic br);
        logic acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = v && model_ready(s, ar, br);
        if (qa.size() != 0 && ar) begin void'(qa.pop_front()); m_ca++; end
        if (qb.size() != 0 && br) begin void'(qb.pop_front()); m_cb++; end
        if (acc && !s) begin qa.push_back(d); last_a = d; end
        if (acc && s)  begin qb.push_back(d); last_b = d; end
    endtask

    initial begin
        //          rst   v     s     data          ar    br    ir    av    a             bv    b             ca cb
        vec[0]  = '{1'b0, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 1'b0, 32'h0,        0, 0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h0,        1, 0};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b1, 32'h55555555, 1, 0};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 32'h87654321, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b1, 32'h55555555, 1, 0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 32'h87654321, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, 1'b1, 32'h87654321, 1, 1};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 32'h87654321, 1, 1};
        vec[6]  = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 32'h87654321, 1, 1};
        vec[7]  = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 32'h87654321, 2, 2};
        vec[8]  = '{1'b0, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000001, 1'b0, 32'h87654321, 2, 2};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000002, 1'b0, 32'h87654321, 3, 2};
        vec[10] = '{1'b0, 1'b1, 1'b0, 32'h00000003, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000003, 1'b0, 32'h87654321, 4, 2};
        vec[11] = '{1'b0, 1'b1, 1'b0, 32'h00000004, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000004, 1'b0, 32'h87654321, 5, 2};
        vec[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h00000004, 1'b0, 32'h87654321, 6, 2};
        vec[13] = '{1'b0, 1'b1, 1'b0, 32'h00000009, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000009, 1'b0, 32'h87654321, 6, 2};
        vec[14] = '{1'b0, 1'b1, 1'b1, 32'h00000007, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000009, 1'b1, 32'h00000007, 6, 2};
        vec[15] = '{1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        0, 0};
        vec[16] = '{1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        0, 0};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("reset_a_valid", A_Valid, 1'b0);
        chk("reset_b_valid", B_Valid, 1'b0);
        chk("reset_a", A, 32'h0);
        chk("reset_b", B, 32'h0);
        chk("reset_count_a", Count_A, ec(0));
        chk("reset_count_b", Count_B, ec(0));
        chk("reset_in_ready_sel0", In_Ready, 1'b1);
        Sel = 1'b1; #1;
        chk("reset_in_ready_sel1", In_Ready, 1'b1);

        for (int i = 0; i < 17; i++) begin
            drive(vec[i].rst, vec[i].v, vec[i].s, vec[i].d, vec[i].ar, vec[i].br);
            chk($sformatf("vec%0d_in_ready", i), In_Ready, vec[i].ir);
            tick();
            chk($sformatf("vec%0d_a_valid", i), A_Valid, vec[i].av);
            chk($sformatf("vec%0d_a", i), A, vec[i].a);
            chk($sformatf("vec%0d_b_valid", i), B_Valid, vec[i].bv);
            chk($sformatf("vec%0d_b", i), B, vec[i].b);
            chk($sformatf("vec%0d_count_a", i), Count_A, ec(vec[i].ca));
            chk($sformatf("vec%0d_count_b", i), Count_B, ec(vec[i].cb));
        end

        // Counter wrap: 256 back-to-back words delivered on B.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'(i + 32'h100), 1'b0, 1'b1);
            chk("wrap_in_ready", In_Ready, 1'b1);
            tick();
            chk("wrap_count_b_running", Count_B, ec(i));
        end
        chk("wrap_b_last", B, 32'h1FF);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        tick();
        chk("wrap_count_b_end", Count_B, ec(256));
        chk("wrap_b_valid_end", B_Valid, 1'b0);
        chk("wrap_count_a_untouched", Count_A, ec(0));

        // Randomized traffic against the queue model, with occasional mid-stream reset.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_v, r_s, r_ar, r_br;
            logic [31:0] r_d;
            r_rst = ($urandom_range(0, 99) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_s   = 1'($urandom);
            r_d   = $urandom;
            r_ar  = ($urandom_range(0, 2) != 0);
            r_br  = ($urandom_range(0, 3) == 0);
            drive(r_rst, r_v, r_s, r_d, r_ar, r_br);
            chk("rand_in_ready", In_Ready, model_ready(r_s, r_ar, r_br));
            tick();
            model_step(r_rst, r_v, r_s, r_d, r_ar, r_br);
            chk("rand_a_valid", A_Valid, qa.size() != 0);
            chk("rand_b_valid", B_Valid, qb.size() != 0);
            chk("rand_a", A, last_a);
            chk("rand_b", B, last_b);
            chk("rand_count_a", Count_A, ec(m_ca));
            chk("rand_count_b", Count_B, ec(m_cb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
